data_mem_ctrl: RTL and testbench

Initiator-side controller for the processor's single-port data memory (16 words × 32 bits, write committed on the falling clock edge while write-enable is high, read data registered on the rising edge). Accepts one load/store request at a time from the core over a valid/ready handshake. Drives the memory's address, write-enable and write-data pins, and absorbs the memory's read latency. Returns a single-cycle response pulse with read data or an error flag.

---
 rtl/data_mem_ctrl_pkg.sv | 21 ++
 rtl/data_mem_ctrl.sv | 158 +++++++++++++++
 tb/tb_data_mem_ctrl.sv | 273 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/data_mem_ctrl_pkg.sv
// Shared types and default sizes for the data-memory controller.
package data_mem_ctrl_pkg;

    localparam int DEFAULT_ADDR_W = 4;
    localparam int DEFAULT_DATA_W = 32;

    typedef enum logic [1:0] {
        OP_LOAD  = 2'b00,
        OP_STORE = 2'b01,
        OP_FADD  = 2'b10,
        OP_RSVD  = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        WRITE   = 2'b01,
        RD_WAIT = 2'b10,
        RD_CAPT = 2'b11
    } state_e;

endpackage

// File: rtl/data_mem_ctrl.sv
// Single-outstanding load/store controller for a 1-cycle-latency data memory.
// Define DATA_MEM_CTRL_FADD_EN to enable the atomic fetch-and-add op (10).
module data_mem_ctrl
    import data_mem_ctrl_pkg::*;
#(
    parameter int ADDR_W = DEFAULT_ADDR_W,
    parameter int DATA_W = DEFAULT_DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [1:0]        req_op,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              resp_valid,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              resp_err,
    output logic [ADDR_W-1:0] mem_address,
    output logic              mem_writeEnable,
    output logic [DATA_W-1:0] mem_writeData,
    input  logic [DATA_W-1:0] mem_data
);

    state_e            state, state_n;
    logic [ADDR_W-1:0] address_n;
    logic              write_en_n;
    logic [DATA_W-1:0] write_data_n;
    logic              resp_valid_n;
    logic              resp_err_n;
    logic [DATA_W-1:0] resp_rdata_n;

`ifdef DATA_MEM_CTRL_FADD_EN
    logic              fadd_q, fadd_n;
    logic [DATA_W-1:0] operand_q, operand_n;
    logic [DATA_W-1:0] old_q, old_n;

    // Carry out is intentionally dropped: the sum wraps modulo 2^DATA_W.
    function automatic logic [DATA_W-1:0] wrap_add(input logic [DATA_W-1:0] a,
                                                   input logic [DATA_W-1:0] b);
        return a + b;
    endfunction
`endif

    assign req_ready = (state == IDLE) && !rst;

    always_comb begin
        state_n      = state;
        address_n    = mem_address;
        write_en_n   = 1'b0;
        write_data_n = mem_writeData;
        resp_valid_n = 1'b0;
        resp_err_n   = 1'b0;
        resp_rdata_n = '0;
`ifdef DATA_MEM_CTRL_FADD_EN
        fadd_n    = fadd_q;
        operand_n = operand_q;
        old_n     = old_q;
`endif
        case (state)
            IDLE: begin
                if (req_valid) begin
                    case (op_e'(req_op))
                        OP_LOAD: begin
                            address_n = req_addr;
                            state_n   = RD_WAIT;
`ifdef DATA_MEM_CTRL_FADD_EN
                            fadd_n    = 1'b0;
`endif
                        end
                        OP_STORE: begin
                            address_n    = req_addr;
                            write_en_n   = 1'b1;
                            write_data_n = req_wdata;
                            state_n      = WRITE;
`ifdef DATA_MEM_CTRL_FADD_EN
                            fadd_n       = 1'b0;
`endif
                        end
`ifdef DATA_MEM_CTRL_FADD_EN
                        OP_FADD: begin
                            address_n = req_addr;
                            operand_n = req_wdata;
                            fadd_n    = 1'b1;
                            state_n   = RD_WAIT;
                        end
`endif
                        // Illegal ops answer immediately and leave the memory pins alone.
                        default: begin
                            resp_valid_n = 1'b1;
                            resp_err_n   = 1'b1;
                        end
                    endcase
                end
            end
            WRITE: begin
                state_n      = IDLE;
                resp_valid_n = 1'b1;
`ifdef DATA_MEM_CTRL_FADD_EN
                resp_rdata_n = fadd_q ? old_q : '0;
`endif
            end
            RD_WAIT: begin
                state_n = RD_CAPT;
            end
            RD_CAPT: begin
`ifdef DATA_MEM_CTRL_FADD_EN
                if (fadd_q) begin
                    old_n        = mem_data;
                    write_en_n   = 1'b1;
                    write_data_n = wrap_add(mem_data, operand_q);
                    state_n      = WRITE;
                end else begin
                    resp_rdata_n = mem_data;
                    resp_valid_n = 1'b1;
                    state_n      = IDLE;
                end
`else
                resp_rdata_n = mem_data;
                resp_valid_n = 1'b1;
                state_n      = IDLE;
`endif
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= IDLE;
            mem_address     <= '0;
            mem_writeEnable <= 1'b0;
            mem_writeData   <= '0;
            resp_valid      <= 1'b0;
            resp_err        <= 1'b0;
            resp_rdata      <= '0;
`ifdef DATA_MEM_CTRL_FADD_EN
            fadd_q          <= 1'b0;
            operand_q       <= '0;
            old_q           <= '0;
`endif
        end else begin
            state           <= state_n;
            mem_address     <= address_n;
            mem_writeEnable <= write_en_n;
            mem_writeData   <= write_data_n;
            resp_valid      <= resp_valid_n;
            resp_err        <= resp_err_n;
            resp_rdata      <= resp_rdata_n;
`ifdef DATA_MEM_CTRL_FADD_EN
            fadd_q          <= fadd_n;
            operand_q       <= operand_n;
            old_q           <= old_n;
`endif
        end
    end

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Directed bench for data_mem_ctrl with a transaction-level model and per-cycle compare.
// Honours DATA_MEM_CTRL_FADD_EN the same way the design does.
module tb_data_mem_ctrl;

    localparam logic [31:0] RAM_INIT [16] = '{
        32'h1000_0000, 32'h1000_0001, 32'h1000_0002, 32'h1000_0003,
        32'h1000_0004, 32'd10,        32'h1000_0006, 32'h1000_0007,
        32'h1000_0008, 32'h1000_0009, 32'h1000_000A, 32'h1000_000B,
        32'h1000_000C, 32'h1000_000D, 32'h1000_000E, 32'h1000_000F
    };

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [1:0]  req_op = 2'b00;
    logic [3:0]  req_addr = 4'd0;
    logic [31:0] req_wdata = 32'd0;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic [3:0]  mem_address;
    logic        mem_writeEnable;
    logic [31:0] mem_writeData;
    logic [31:0] mem_data = 32'd0;

    int n_cmp  = 0;
    int n_fail = 0;

    data_mem_ctrl dut (
        .clk             (clk),
        .rst             (rst),
        .req_valid       (req_valid),
        .req_ready       (req_ready),
        .req_op          (req_op),
        .req_addr        (req_addr),
        .req_wdata       (req_wdata),
        .resp_valid      (resp_valid),
        .resp_rdata      (resp_rdata),
        .resp_err        (resp_err),
        .mem_address     (mem_address),
        .mem_writeEnable (mem_writeEnable),
        .mem_writeData   (mem_writeData),
        .mem_data        (mem_data)
    );

    always #5 clk = ~clk;

    // Memory device: write on falling edge, registered read on rising edge.
    logic [31:0] ram [16] = RAM_INIT;
    always @(negedge clk) if (mem_writeEnable) ram[mem_address] <= mem_writeData;
    always @(posedge clk) mem_data <= ram[mem_address];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h required %h at %0t", name, got, exp, $time);
        end
    endtask

    // Transaction model: each accepted op has a fixed number of edges until its response.
    logic [31:0] m_ram [16] = RAM_INIT;
    int          rem = 0;
    int          cyc = 0;
    logic [1:0]  p_op = 2'b00;
    logic [31:0] p_res = 32'd0;
    logic [31:0] p_wd = 32'd0;
    logic        m_rv = 1'b0, m_err = 1'b0, m_we = 1'b0;
    logic [31:0] m_rd = 32'd0;
    logic [3:0]  m_addr = 4'd0;

    function automatic bit m_legal(input logic [1:0] op);
`ifdef DATA_MEM_CTRL_FADD_EN
        return op != 2'b11;
`else
        return op == 2'b00 || op == 2'b01;
`endif
    endfunction

    always @(posedge clk) begin
        cyc++;
        m_rv  = 1'b0;
        m_err = 1'b0;
        m_rd  = 32'd0;
        if (rst) begin
            rem    = 0;
            m_addr = 4'd0;
        end else if (rem > 0) begin
            rem--;
            if (rem == 0) begin
                m_rv = 1'b1;
                m_rd = p_res;
            end
        end else if (req_valid) begin
            if (m_legal(req_op)) begin
                m_addr = req_addr;
                p_op   = req_op;
                case (req_op)
                    2'b00: begin p_res = m_ram[req_addr]; rem = 2; end
                    2'b01: begin p_res = 32'd0; p_wd = req_wdata; m_ram[req_addr] = req_wdata; rem = 1; end
                    default: begin
                        p_res = m_ram[req_addr];
                        p_wd  = p_res + req_wdata;
                        m_ram[req_addr] = p_wd;
                        rem = 3;
                    end
                endcase
            end else begin
                m_rv  = 1'b1;
                m_err = 1'b1;
            end
        end
        m_we = (rem == 1) && (p_op != 2'b00);
    end

    always @(negedge clk) begin
        if (cyc > 0) begin
            chk("resp_valid", 32'(resp_valid), 32'(m_rv));
            chk("resp_err", 32'(resp_err), 32'(m_err));
            if (m_rv) chk("resp_rdata", resp_rdata, m_rd);
            chk("req_ready", 32'(req_ready), 32'(!rst && rem == 0));
            chk("mem_writeEnable", 32'(mem_writeEnable), 32'(m_we));
            chk("mem_address", 32'(mem_address), 32'(m_addr));
            if (m_we) chk("mem_writeData", mem_writeData, p_wd);
        end
    end

    task automatic accept(input logic [1:0] op, input logic [3:0] addr, input logic [31:0] data,
                          output int waited);
        req_valid = 1'b1;
        req_op    = op;
        req_addr  = addr;
        req_wdata = data;
        waited    = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            waited++;
            if (req_ready) begin
                @(posedge clk);
                #2;
                return;
            end
        end
        chk("accept_timeout", 32'd0, 32'd1);
    endtask

    task automatic wait_resp(output logic [31:0] rdata, output logic err, output int lat,
                             output int we_cnt, output logic [3:0] we_addr);
        lat     = 0;
        we_cnt  = 0;
        we_addr = 4'd0;
        rdata   = 32'd0;
        err     = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            lat++;
            if (mem_writeEnable) begin
                we_cnt++;
                we_addr = mem_address;
            end
            if (resp_valid) begin
                rdata = resp_rdata;
                err   = resp_err;
                return;
            end
        end
        chk("resp_timeout", 32'd0, 32'd1);
    endtask

    task automatic do_op(input string name, input logic [1:0] op, input logic [3:0] addr,
                         input logic [31:0] data, input logic [31:0] exp_rdata,
                         input logic exp_err, input int exp_lat, input int exp_we);
        int w, lat, wc;
        logic [31:0] rd;
        logic e;
        logic [3:0] wa;
        accept(op, addr, data, w);
        req_valid = 1'b0;
        wait_resp(rd, e, lat, wc, wa);
        chk({name, "_rdata"}, rd, exp_rdata);
        chk({name, "_err"}, 32'(e), 32'(exp_err));
        chk({name, "_latency"}, 32'(lat), 32'(exp_lat));
        chk({name, "_we_cycles"}, 32'(wc), 32'(exp_we));
        if (exp_we > 0) chk({name, "_we_addr"}, 32'(wa), 32'(addr));
    endtask

    initial begin
        int w, lat, wc;
        logic [31:0] rd;
        logic e;
        logic [3:0] wa;

        // Reset held for three edges; everything must read zero.
        @(posedge clk);
        @(negedge clk);
        chk("rst_resp_valid", 32'(resp_valid), 32'd0);
        chk("rst_resp_err", 32'(resp_err), 32'd0);
        chk("rst_resp_rdata", resp_rdata, 32'd0);
        chk("rst_mem_address", 32'(mem_address), 32'd0);
        chk("rst_mem_we", 32'(mem_writeEnable), 32'd0);
        chk("rst_mem_wdata", mem_writeData, 32'd0);
        chk("rst_req_ready", 32'(req_ready), 32'd0);
        @(posedge clk);
        @(posedge clk);
        #2 rst = 1'b0;
        @(negedge clk);
        chk("ready_after_rst", 32'(req_ready), 32'd1);
        @(posedge clk);
        #2;

        do_op("store3", 2'b01, 4'd3, 32'hDEAD_BEEF, 32'd0, 1'b0, 2, 1);
        do_op("load3", 2'b00, 4'd3, 32'd0, 32'hDEAD_BEEF, 1'b0, 3, 0);

        // Back-to-back: STORE held valid behind a LOAD is taken three edges later.
        accept(2'b00, 4'd7, 32'd0, w);
        accept(2'b01, 4'd8, 32'h1234_5678, w);
        chk("b2b_wait", 32'(w), 32'd3);
        req_valid = 1'b0;
        wait_resp(rd, e, lat, wc, wa);
        chk("b2b_store_latency", 32'(lat), 32'd2);
        chk("b2b_store_we_addr", 32'(wa), 32'd8);
        do_op("load8", 2'b00, 4'd8, 32'd0, 32'h1234_5678, 1'b0, 3, 0);
        do_op("load7", 2'b00, 4'd7, 32'd0, 32'h1000_0007, 1'b0, 3, 0);

        do_op("rsvd", 2'b11, 4'd9, 32'h5555_AAAA, 32'd0, 1'b1, 1, 0);
        chk("rsvd_addr_kept", 32'(mem_address), 32'd7);

`ifdef DATA_MEM_CTRL_FADD_EN
        do_op("fadd5", 2'b10, 4'd5, 32'hFFFF_FFF8, 32'd10, 1'b0, 4, 1);
        do_op("load5", 2'b00, 4'd5, 32'd0, 32'd2, 1'b0, 3, 0);
`else
        do_op("fadd_off", 2'b10, 4'd5, 32'hFFFF_FFF8, 32'd0, 1'b1, 1, 0);
        do_op("load5", 2'b00, 4'd5, 32'd0, 32'd10, 1'b0, 3, 0);
`endif

        // An error response leaves the controller ready on the very next edge.
        accept(2'b11, 4'd1, 32'd0, w);
        accept(2'b00, 4'd3, 32'd0, w);
        chk("err_then_load_wait", 32'(w), 32'd1);
        req_valid = 1'b0;
        wait_resp(rd, e, lat, wc, wa);
        chk("err_then_load_rdata", rd, 32'hDEAD_BEEF);

        // Reset while the load sits in its wait cycle: no response may appear.
        accept(2'b00, 4'd3, 32'd0, w);
        req_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #2 rst = 1'b0;
        @(negedge clk);
        chk("midrst_ready", 32'(req_ready), 32'd1);
        for (int i = 0; i < 4; i++) begin
            chk("midrst_no_resp", 32'(resp_valid), 32'd0);
            @(negedge clk);
        end
        @(posedge clk);
        #2;
        do_op("load3_after_rst", 2'b00, 4'd3, 32'd0, 32'hDEAD_BEEF, 1'b0, 3, 0);

        repeat (2) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1, "watchdog");
    end

endmodule
